// File: rtl/axis_frame_pkg.sv
// Shared types and constants for the AXI4-Stream frame checker.
package axis_frame_pkg;

    localparam int unsigned ERR_W          = 7;
    localparam int unsigned ERR_NO_SOF     = 0;
    localparam int unsigned ERR_HDR_DEST   = 1;
    localparam int unsigned ERR_RANGE      = 2;
    localparam int unsigned ERR_DUP_SOF    = 3;
    localparam int unsigned ERR_DEST_CHG   = 4;
    localparam int unsigned ERR_VALID_DROP = 5;
    localparam int unsigned ERR_UNSTABLE   = 6;

    typedef enum logic [1:0] {
        RdyOn   = 2'd0,
        RdyOsc  = 2'd1,
        RdyHold = 2'd2
    } ready_mode_e;

    typedef enum logic {
        StIdle  = 1'b0,
        StInPkt = 1'b1
    } state_e;

    typedef enum logic {
        PhLow  = 1'b0,
        PhHigh = 1'b1
    } ready_phase_e;

    function automatic logic [7:0] eff_time(input logic [7:0] t);
        return (t == 8'd0) ? 8'd1 : t;
    endfunction

    // Encoding 3 aliases mode 0.
    function automatic ready_mode_e decode_mode(input logic [1:0] m);
        ready_mode_e r;
        case (m)
            2'd1:    r = RdyOsc;
            2'd2:    r = RdyHold;
            default: r = RdyOn;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/axis_ready_gen.sv
// Programmable back-pressure generator; tready is the phase delayed by one register.
module axis_ready_gen
    import axis_frame_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] cfg_ready_mode,
    input  logic [7:0] cfg_low_time,
    input  logic [7:0] cfg_high_time,
    output logic       tready
);

    ready_mode_e  mode_q, mode_d;
    ready_phase_e phase_q, phase_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [7:0]   low_q, low_d;
    logic [7:0]   high_q, high_d;
    logic         tready_q, tready_d;
    logic [7:0]   phase_len;
    logic         boundary;

    always_comb begin
        mode_d    = mode_q;
        phase_d   = phase_q;
        low_d     = low_q;
        high_d    = high_q;
        cnt_d     = cnt_q + 8'd1;
        phase_len = (phase_q == PhHigh) ? eff_time(high_q) : eff_time(low_q);
        // Outside oscillation every cycle is a boundary, so config is sampled continuously.
        boundary  = (mode_q != RdyOsc) || (cnt_q == phase_len - 8'd1);
        if (boundary) begin
            mode_d = decode_mode(cfg_ready_mode);
            low_d  = cfg_low_time;
            high_d = cfg_high_time;
            cnt_d  = '0;
            case (mode_d)
                RdyOsc:  phase_d = (mode_q == RdyOsc && phase_q == PhLow) ? PhHigh : PhLow;
                RdyHold: phase_d = PhLow;
                default: phase_d = PhHigh;
            endcase
        end
        tready_d = (phase_q == PhHigh);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= RdyOn;
            phase_q  <= PhLow;
            cnt_q    <= '0;
            low_q    <= '0;
            high_q   <= '0;
            tready_q <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            low_q    <= low_d;
            high_q   <= high_d;
            tready_q <= tready_d;
        end
    end

    assign tready = tready_q;

endmodule

// File: rtl/axis_frame_checker.sv
// AXI4-Stream sink: frame/handshake checking, per-destination packet counters.
module axis_frame_checker
    import axis_frame_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEST_W = 8,
    parameter int unsigned USER_W = 4,
    parameter int unsigned N_CHAN = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic [DATA_W-1:0]       s_axis_tdata,
    input  logic                    s_axis_tlast,
    input  logic [DEST_W-1:0]       s_axis_tdest,
    input  logic [USER_W-1:0]       s_axis_tuser,
    input  logic [1:0]              cfg_ready_mode,
    input  logic [7:0]              cfg_low_time,
    input  logic [7:0]              cfg_high_time,
    input  logic                    clr,
    output logic [N_CHAN*CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0]        beat_cnt,
    output logic                    in_pkt,
    output logic [ERR_W-1:0]        err_pulse,
    output logic [ERR_W-1:0]        err_sticky
);

    localparam int unsigned CH_W  = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
    localparam int unsigned PAY_W = DATA_W + 1 + DEST_W + USER_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic in_range(input logic [DEST_W-1:0] d);
        return {1'b0, d} < (DEST_W + 1)'(N_CHAN);
    endfunction

    logic              tready;
    state_e            state_q, state_d;
    logic [DEST_W-1:0] dest_q, dest_d;
    logic              prev_valid_q, prev_ready_q;
    logic [PAY_W-1:0]  prev_payload_q, payload;
    logic [CNT_W-1:0]  pkt_cnt_q [N_CHAN];
    logic [CNT_W-1:0]  pkt_cnt_d [N_CHAN];
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [ERR_W-1:0]  err, err_pulse_q, err_sticky_q, err_sticky_d;
    logic [DEST_W-1:0] hdr_dest;
    logic [CH_W-1:0]   chan;
    logic              beat, pkt_done;

    axis_ready_gen u_ready_gen (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_ready_mode (cfg_ready_mode),
        .cfg_low_time   (cfg_low_time),
        .cfg_high_time  (cfg_high_time),
        .tready         (tready)
    );

    assign payload = {s_axis_tdata, s_axis_tlast, s_axis_tdest, s_axis_tuser};

    always_comb begin
        state_d  = state_q;
        dest_d   = dest_q;
        err      = '0;
        pkt_done = 1'b0;
        hdr_dest = s_axis_tdata[DATA_W-1 -: DEST_W];
        beat     = s_axis_tvalid & tready;
        // Last cycle offered a beat that was not taken: it must still be offered unchanged.
        if (prev_valid_q && !prev_ready_q) begin
            if (!s_axis_tvalid) begin
                err[ERR_VALID_DROP] = 1'b1;
            end else if (payload != prev_payload_q) begin
                err[ERR_UNSTABLE] = 1'b1;
            end
        end
        if (beat) begin
            if (state_q == StIdle || s_axis_tuser[0]) begin
                err[ERR_NO_SOF]   = (state_q == StIdle) && !s_axis_tuser[0];
                err[ERR_DUP_SOF]  = (state_q == StInPkt);
                err[ERR_HDR_DEST] = (hdr_dest != s_axis_tdest);
                err[ERR_RANGE]    = !in_range(s_axis_tdest);
                dest_d            = s_axis_tdest;
            end else begin
                err[ERR_DEST_CHG] = (s_axis_tdest != dest_q);
            end
            state_d  = s_axis_tlast ? StIdle : StInPkt;
            pkt_done = s_axis_tlast;
        end
    end

    always_comb begin
        beat_cnt_d   = beat_cnt_q;
        err_sticky_d = err_sticky_q | err;
        chan         = dest_d[CH_W-1:0];
        for (int i = 0; i < int'(N_CHAN); i++) begin
            pkt_cnt_d[i] = pkt_cnt_q[i];
        end
        if (beat && beat_cnt_q != CNT_MAX) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
        if (pkt_done && in_range(dest_d) && pkt_cnt_q[chan] != CNT_MAX) begin
            pkt_cnt_d[chan] = pkt_cnt_q[chan] + CNT_W'(1);
        end
        if (clr) begin
            beat_cnt_d   = '0;
            err_sticky_d = '0;
            for (int i = 0; i < int'(N_CHAN); i++) begin
                pkt_cnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            dest_q         <= '0;
            prev_valid_q   <= 1'b0;
            prev_ready_q   <= 1'b0;
            prev_payload_q <= '0;
            beat_cnt_q     <= '0;
            err_pulse_q    <= '0;
            err_sticky_q   <= '0;
            for (int i = 0; i < int'(N_CHAN); i++) begin
                pkt_cnt_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            dest_q         <= dest_d;
            prev_valid_q   <= s_axis_tvalid;
            prev_ready_q   <= tready;
            prev_payload_q <= payload;
            beat_cnt_q     <= beat_cnt_d;
            err_pulse_q    <= err;
            err_sticky_q   <= err_sticky_d;
            for (int i = 0; i < int'(N_CHAN); i++) begin
                pkt_cnt_q[i] <= pkt_cnt_d[i];
            end
        end
    end

    for (genvar g = 0; g < int'(N_CHAN); g++) begin : g_pack
        assign pkt_cnt[g*CNT_W +: CNT_W] = pkt_cnt_q[g];
    end

    assign s_axis_tready = tready;
    assign beat_cnt      = beat_cnt_q;
    assign in_pkt        = (state_q == StInPkt);
    assign err_pulse     = err_pulse_q;
    assign err_sticky    = err_sticky_q;

endmodule

// File: tb/tb_axis_frame_checker.sv
// Randomised bench for axis_frame_checker against a packet-level reference model.
module tb_axis_frame_checker;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEST_W = 8;
    localparam int unsigned USER_W = 4;
    localparam int unsigned N_CHAN = 4;
    localparam int unsigned CNT_W  = 16;
    localparam int          CMAX   = 65535;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tvalid = 1'b0, tready, tlast = 1'b0, clr = 1'b0;
    logic [31:0] tdata = '0;
    logic [7:0]  tdest = '0, low_t = '0, high_t = '0;
    logic [3:0]  tuser = '0;
    logic [1:0]  mode = 2'd0;
    logic [63:0] pkt_cnt;
    logic [15:0] beat_cnt;
    logic        in_pkt;
    logic [6:0]  err_pulse, err_sticky;

    always #5 clk = ~clk;

    axis_frame_checker #(
        .DATA_W (DATA_W),
        .DEST_W (DEST_W),
        .USER_W (USER_W),
        .N_CHAN (N_CHAN),
        .CNT_W  (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_axis_tvalid  (tvalid),
        .s_axis_tready  (tready),
        .s_axis_tdata   (tdata),
        .s_axis_tlast   (tlast),
        .s_axis_tdest   (tdest),
        .s_axis_tuser   (tuser),
        .cfg_ready_mode (mode),
        .cfg_low_time   (low_t),
        .cfg_high_time  (high_t),
        .clr            (clr),
        .pkt_cnt        (pkt_cnt),
        .beat_cnt       (beat_cnt),
        .in_pkt         (in_pkt),
        .err_pulse      (err_pulse),
        .err_sticky     (err_sticky)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: what the outputs must show after the next edge.
    int        m_pkt [N_CHAN];
    int        m_beats;
    bit        m_open;
    int        m_dest;
    bit [6:0]  m_pulse, m_sticky;
    bit        p_vld, p_rdy;
    bit [44:0] p_payload;
    bit        rnd_en = 1'b0;
    bit        rec = 1'b0;
    bit        rdy_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    function automatic int eff(input int t);
        return (t == 0) ? 1 : t;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(N_CHAN); i++) m_pkt[i] = 0;
        m_beats  = 0;
        m_open   = 1'b0;
        m_dest   = 0;
        m_pulse  = '0;
        m_sticky = '0;
        p_vld    = 1'b0;
        p_rdy    = 1'b0;
        p_payload = '0;
    endtask

    task automatic model_step();
        bit        beat;
        bit [6:0]  e;
        bit [44:0] pay;
        bit        done;
        pay  = {tdata, tlast, tdest, tuser};
        beat = tvalid && tready;
        e    = '0;
        done = 1'b0;
        if (p_vld && !p_rdy) begin
            if (!tvalid) e[5] = 1'b1;
            else if (pay != p_payload) e[6] = 1'b1;
        end
        if (beat) begin
            if (!m_open || tuser[0]) begin
                if (!m_open && !tuser[0]) e[0] = 1'b1;
                if (m_open) e[3] = 1'b1;
                if (int'(tdata[31:24]) != int'(tdest)) e[1] = 1'b1;
                if (int'(tdest) >= int'(N_CHAN)) e[2] = 1'b1;
                m_dest = int'(tdest);
            end else if (int'(tdest) != m_dest) begin
                e[4] = 1'b1;
            end
            m_open = !tlast;
            done   = tlast;
        end
        m_pulse = e;
        if (clr) begin
            for (int i = 0; i < int'(N_CHAN); i++) m_pkt[i] = 0;
            m_beats  = 0;
            m_sticky = '0;
        end else begin
            if (beat) m_beats = sat_inc(m_beats);
            if (done && m_dest < int'(N_CHAN)) m_pkt[m_dest] = sat_inc(m_pkt[m_dest]);
            m_sticky = m_sticky | e;
        end
        p_vld     = tvalid;
        p_rdy     = tready;
        p_payload = pay;
    endtask

    task automatic check_outputs();
        for (int i = 0; i < int'(N_CHAN); i++) begin
            chk($sformatf("pkt_cnt[%0d]", i), 64'(pkt_cnt[i*16 +: 16]), 64'(m_pkt[i]));
        end
        chk("beat_cnt", 64'(beat_cnt), 64'(m_beats));
        chk("in_pkt", 64'(in_pkt), 64'(m_open));
        chk("err_pulse", 64'(err_pulse), 64'(m_pulse));
        chk("err_sticky", 64'(err_sticky), 64'(m_sticky));
    endtask

    task automatic gen_random();
        int d;
        int hdr;
        bit sof;
        if (p_vld && !p_rdy && $urandom_range(0, 99) < 96) begin
            // keep offering the same beat
        end else if (p_vld && !p_rdy) begin
            if ($urandom_range(0, 1) == 1) tvalid = 1'b0;
            else tdata = tdata ^ 32'h1;
        end else begin
            tvalid = ($urandom_range(0, 99) < 70);
            sof    = m_open ? ($urandom_range(0, 99) < 5) : ($urandom_range(0, 99) < 95);
            d      = (m_open && $urandom_range(0, 99) < 95) ? m_dest
                                                             : int'($urandom_range(0, N_CHAN));
            if ($urandom_range(0, 49) == 0) d = int'($urandom_range(0, 255));
            hdr    = ($urandom_range(0, 99) < 95) ? d : int'($urandom_range(0, 255));
            tdata  = {8'(hdr), 24'($urandom)};
            tlast  = ($urandom_range(0, 99) < 30);
            tdest  = 8'(d);
            tuser  = {3'($urandom), sof};
        end
        clr = ($urandom_range(0, 199) == 0);
    endtask

    task automatic cycle();
        if (rnd_en) gen_random();
        if (rst_n) model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        tvalid = 1'b0;
        clr    = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic send_beat(input logic [31:0] d, input logic l, input logic [7:0] ds,
                             input logic [3:0] u);
        bit acc;
        int guard;
        tvalid = 1'b1;
        tdata  = d;
        tlast  = l;
        tdest  = ds;
        tuser  = u;
        guard  = 0;
        acc    = 1'b0;
        while (!acc && guard < 600) begin
            acc = (tready === 1'b1);
            if (rec) rdy_q.push_back(tready);
            cycle();
            guard++;
        end
        if (!acc) chk("send_beat_timeout", 64'd1, 64'd0);
        tvalid = 1'b0;
    endtask

    task automatic check_osc(input int lo, input int hi, input int periods);
        int guard;
        int run;
        guard = 0;
        while (tready !== 1'b0 && guard < 600) begin cycle(); guard++; end
        while (tready !== 1'b1 && guard < 600) begin cycle(); guard++; end
        if (guard >= 600) begin
            chk("osc_timeout", 64'd1, 64'd0);
        end else begin
            for (int p = 0; p < periods; p++) begin
                run = 0;
                while (tready === 1'b1 && run < 600) begin cycle(); run++; end
                chk("osc_high_run", 64'(run), 64'(hi));
                run = 0;
                while (tready === 1'b0 && run < 600) begin cycle(); run++; end
                chk("osc_low_run", 64'(run), 64'(lo));
            end
        end
    endtask

    initial begin
        int s;
        int m;
        int lo;
        int hi;
        model_reset();

        // Reset values and tready release timing.
        @(negedge clk);
        @(negedge clk);
        chk("rst_tready", 64'(tready), 64'd0);
        check_outputs();
        rst_n = 1'b1;
        cycle();
        chk("tready_edge1", 64'(tready), 64'd0);
        cycle();
        chk("tready_edge2", 64'(tready), 64'd1);

        // Basic 3-beat packet to channel 2.
        send_beat(32'h02000001, 1'b0, 8'd2, 4'h1);
        send_beat(32'h00000011, 1'b0, 8'd2, 4'h0);
        send_beat(32'h00000022, 1'b1, 8'd2, 4'h0);
        idle(1);
        chk("t1_pkt2", 64'(pkt_cnt[32 +: 16]), 64'd1);
        chk("t1_beats", 64'(beat_cnt), 64'd3);
        chk("t1_sticky", 64'(err_sticky), 64'd0);

        // Oscillating ready, low=1 high=2, 10-beat packet held valid.
        mode   = 2'd1;
        low_t  = 8'd1;
        high_t = 8'd2;
        idle(5);
        rec = 1'b1;
        send_beat(32'h01000000, 1'b0, 8'd1, 4'h1);
        for (int i = 1; i < 10; i++) send_beat(32'(i), (i == 9), 8'd1, 4'h0);
        rec = 1'b0;
        s = 0;
        while (s < rdy_q.size() && rdy_q[s] != 1'b0) s++;
        for (int k = s; k < rdy_q.size(); k++) begin
            chk("t2_ready_pattern", 64'(rdy_q[k]), 64'(((k - s) % 3) != 0));
        end
        idle(1);
        chk("t2_pkt1", 64'(pkt_cnt[16 +: 16]), 64'd1);
        chk("t2_beats", 64'(beat_cnt), 64'd13);
        chk("t2_sticky", 64'(err_sticky), 64'd0);

        // Missing SOF plus header mismatch on a single-beat packet to channel 3.
        mode = 2'd0;
        idle(4);
        send_beat(32'h01000005, 1'b1, 8'd3, 4'h0);
        chk("t3_pulse", 64'(err_pulse), 64'h03);
        chk("t3_pkt3", 64'(pkt_cnt[48 +: 16]), 64'd1);

        // Duplicate SOF mid-packet: only the restarted packet counts.
        send_beat(32'h00000000, 1'b0, 8'd0, 4'h1);
        send_beat(32'h000000AA, 1'b0, 8'd0, 4'h0);
        send_beat(32'h00000000, 1'b0, 8'd0, 4'h1);
        chk("t4_pulse", 64'(err_pulse), 64'h08);
        send_beat(32'h000000BB, 1'b1, 8'd0, 4'h0);
        chk("t4_pkt0", 64'(pkt_cnt[0 +: 16]), 64'd1);

        // Clear, then unstable payload and valid drop under held-low ready.
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        chk("t5_clr_beats", 64'(beat_cnt), 64'd0);
        chk("t5_clr_sticky", 64'(err_sticky), 64'd0);
        mode = 2'd2;
        idle(4);
        chk("t5_tready_low", 64'(tready), 64'd0);
        tvalid = 1'b1;
        tdata  = 32'h03000001;
        tdest  = 8'd3;
        tuser  = 4'h1;
        tlast  = 1'b1;
        cycle();
        tdata = 32'h03000002;
        cycle();
        chk("t5_unstable", 64'(err_pulse), 64'h40);
        tvalid = 1'b0;
        cycle();
        chk("t5_valid_drop", 64'(err_pulse), 64'h20);
        chk("t5_beats", 64'(beat_cnt), 64'd0);

        // Randomised traffic across ready modes.
        mode = 2'd0;
        idle(3);
        rnd_en = 1'b1;
        for (int seg = 0; seg < 8; seg++) begin
            m      = int'($urandom_range(0, 3));
            lo     = int'($urandom_range(0, 6));
            hi     = int'($urandom_range(0, 6));
            mode   = 2'(m);
            low_t  = 8'(lo);
            high_t = 8'(hi);
            for (int i = 0; i < 15; i++) cycle();
            if (m == 0 || m == 3) chk("rnd_tready_on", 64'(tready), 64'd1);
            else if (m == 2) chk("rnd_tready_hold", 64'(tready), 64'd0);
            else check_osc(eff(lo), eff(hi), 2);
            for (int i = 0; i < 300; i++) cycle();
        end
        rnd_en = 1'b0;
        mode   = 2'd0;
        idle(4);

        // Reset in the middle of an open packet.
        send_beat(32'h02000000, 1'b0, 8'd2, 4'h1);
        chk("t7_in_pkt", 64'(in_pkt), 64'd1);
        rst_n = 1'b0;
        model_reset();
        cycle();
        chk("t7_tready", 64'(tready), 64'd0);
        chk("t7_pkt", pkt_cnt, 64'd0);
        chk("t7_beats", 64'(beat_cnt), 64'd0);
        chk("t7_in_pkt_rst", 64'(in_pkt), 64'd0);
        chk("t7_pulse", 64'(err_pulse), 64'd0);
        chk("t7_sticky", 64'(err_sticky), 64'd0);
        rst_n = 1'b1;
        idle(3);

        // Saturate the counters, then clear while traffic keeps flowing.
        tvalid = 1'b1;
        tlast  = 1'b1;
        tuser  = 4'h1;
        tdest  = 8'd0;
        tdata  = 32'h0;
        for (int i = 0; i < CMAX + 5; i++) cycle();
        chk("t8_beats_sat", 64'(beat_cnt), 64'hFFFF);
        chk("t8_pkt0_sat", 64'(pkt_cnt[0 +: 16]), 64'hFFFF);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        chk("t8_clr_beats", 64'(beat_cnt), 64'd0);
        chk("t8_clr_pkt0", 64'(pkt_cnt[0 +: 16]), 64'd0);
        chk("t8_clr_sticky", 64'(err_sticky), 64'd0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axis_frame_checker.md
# axis_frame_checker

Synthesisable AXI4-Stream sink that accepts framed packets, checks framing and handshake rules on every beat, and keeps per-destination packet counters. It is the RTL successor of our simulation-only stream slave: parametrised data/dest width and channel count, programmable back-pressure, and hardware error reporting, so it can terminate streams both in benches and on the FPGA during bring-up.

## Interface
- DATA_W, 32, TDATA width (>= DEST_W)
- DEST_W, 8, TDEST width; also width of the header dest field
- USER_W, 4, TUSER width (>= 1; bit 0 is start-of-frame)
- N_CHAN, 4, tracked destinations (power of 2, <= 2**DEST_W)
- CNT_W, 16, counter width

- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- s_axis_tvalid  in  1
- s_axis_tready  out  1  registered
- s_axis_tdata  in  DATA_W
- s_axis_tlast  in  1
- s_axis_tdest  in  DEST_W
- s_axis_tuser  in  USER_W
- cfg_ready_mode  in  2  0 no back-pressure, 1 oscillate, 2 hold low, 3 = 0
- cfg_low_time  in  8  mode-1 low cycles (0 treated as 1)
- cfg_high_time  in  8  mode-1 high cycles (0 treated as 1)
- clr  in  1  synchronous clear of counters and sticky errors
- pkt_cnt  out  N_CHAN*CNT_W  completed packets per channel, channel i at [i*CNT_W +: CNT_W]
- beat_cnt  out  CNT_W  total accepted beats
- in_pkt  out  1  a packet is open
- err_pulse  out  7  one-cycle error strobes
- err_sticky  out  7  OR-accumulated err_pulse

## Operation
- Beat = cycle with tvalid & tready. Header dest = tdata[DATA_W-1 -: DEST_W].
- FSM IDLE / IN_PKT. Reset -> IDLE.
- IDLE, beat: tuser[0]=0 -> ERR_NO_SOF (bit 0); header dest != tdest -> ERR_HDR_DEST (1); tdest >= N_CHAN -> ERR_RANGE (2). Latch tdest. tlast=0 -> IN_PKT; tlast=1 -> count packet, stay IDLE.
- IN_PKT, beat: tuser[0]=1 -> ERR_DUP_SOF (3), open packet discarded uncounted, beat starts new packet (header/range checks apply, re-latch dest); tdest != latched -> ERR_DEST_CHG (4); tlast=1 -> count packet, IDLE.
- Packet counted into pkt_cnt[latched dest] only if latched dest < N_CHAN.
- Protocol: tvalid 1->0 without beat -> ERR_VALID_DROP (5); tdata/tlast/tdest/tuser change while tvalid & !tready -> ERR_UNSTABLE (6).
- Counters saturate at all-ones. clr wins over a simultaneous increment and error set; clr does not change FSM state.
- Ready modes: 0 tready=1; 1 low cfg_low_time cycles then high cfg_high_time cycles, repeating, starting low; 2 tready=0. Mode/time changes take effect at next phase boundary; switching into mode 1 restarts at low phase.

## Timing
- Reset values: tready 0, all counters 0, in_pkt 0, err_pulse 0, err_sticky 0, FSM IDLE, ready phase low with count 0.
- tready first goes high the second rising edge after rst_n deasserts (mode 0).
- beat_cnt, pkt_cnt, in_pkt, err_pulse, err_sticky update one cycle after the beat/violation edge (latency 1).
- Multiple errors on one beat set all corresponding bits together.
- Reset mid-packet: packet lost, no count, no error.
- No combinational path input -> output.

## Structure
- Package axis_frame_pkg: error-bit localparams (ERR_NO_SOF..ERR_UNSTABLE, ERR_W=7), ready_mode_e enum, state_e enum.
- Sub-module axis_ready_gen: owns mode/low/high counter, outputs registered tready.
- Top holds FSM, stability registers (previous valid/ready/payload), counters.

## Test plan
- Mode 0; packet dest 2: beats 0x02000001(tuser=1), 0x11, 0x22(tlast) -> pkt_cnt[2]=1, beat_cnt=3, err_sticky=0.
- Mode 1, low=1, high=2; 10-beat packet held valid -> tready pattern 0,1,1 repeating, all beats accepted, no errors.
- First beat tuser[0]=0, header dest 1, tdest 3 -> err_pulse bits 0 and 1 in same cycle, pkt counted in channel 3.
- Mid-packet second SOF then tlast -> ERR_DUP_SOF, only one packet counted.
- tdata changed while tready=0 (mode 2) then tvalid dropped -> ERR_UNSTABLE then ERR_VALID_DROP, beat_cnt=0.
- rst_n pulsed mid-packet, then clr with counter at 0xFFFF saturated -> all outputs at reset values; clr clears beat_cnt and err_sticky.
